// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared constants and helpers for the AES column datapath.
//   AES_POLY_RED  : low byte of the GF(2^8) reduction polynomial x^8+x^4+x^3+x+1
//   COEF_*        : MixColumns / InvMixColumns matrix coefficients
//   BYTE_W/ROWS/COL_W : byte, rows-per-column and column widths
//   byte_idx()    : flat byte index of (column, row) in a packed beat
//   xtime()       : multiply-by-x in GF(2^8)
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam logic [7:0] AES_POLY_RED = 8'h1B;

    localparam logic [7:0] COEF_2  = 8'h02;
    localparam logic [7:0] COEF_3  = 8'h03;
    localparam logic [7:0] COEF_9  = 8'h09;
    localparam logic [7:0] COEF_11 = 8'h0B;
    localparam logic [7:0] COEF_13 = 8'h0D;
    localparam logic [7:0] COEF_14 = 8'h0E;

    localparam int BYTE_W = 8;
    localparam int ROWS   = 4;
    localparam int COL_W  = BYTE_W * ROWS;

    typedef logic [BYTE_W-1:0] gf_byte_t;

    // Row 0 sits in the most significant byte of its column, so row r of
    // column c lands at flat byte c*4 + (3 - r).
    function automatic int byte_idx(input int col, input int row);
        return col * ROWS + (ROWS - 1 - row);
    endfunction

    function automatic gf_byte_t xtime(input gf_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
    endfunction

endpackage

// File: rtl/gf_xtime_chain.sv
// ---------------------------------------------------------------------------
// gf_xtime_chain
// Builds the power-of-two multiples of one byte in GF(2^8); every other
// MixColumns coefficient is an XOR of these and the byte itself.
//   a  : input byte
//   x2 : 2*a
//   x4 : 4*a
//   x8 : 8*a
// ---------------------------------------------------------------------------
module gf_xtime_chain
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] x2,
    output logic [7:0] x4,
    output logic [7:0] x8
);

    assign x2 = xtime(a);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);

endmodule

// File: rtl/mix_columns_pipe.sv
// ---------------------------------------------------------------------------
// mix_columns_pipe
// Pipelined AES MixColumns / InvMixColumns over NCOL columns per beat with a
// valid/ready handshake on both sides. Latency is PIPE cycles, throughput one
// beat per cycle, and back-pressure stalls the whole chain without bubbles.
//
// Parameters
//   NCOL : columns per beat (1..4)
//   PIPE : register stages (1..3), equal to the latency in cycles
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : beat present on in_data
//   in_ready  : beat is accepted this cycle
//   in_inv    : 1 = InvMixColumns, 0 = MixColumns
//   in_data   : columns, column c at [32c+31:32c], row 0 in the top byte
//   out_valid : result beat present
//   out_ready : downstream takes the result
//   out_data  : transformed columns, same packing
//
// Build option
//   MIXCOL_FWD_EN : when defined, forward and inverse are both built and
//                   in_inv selects per beat. When undefined the engine is
//                   inverse-only, in_inv is ignored and no mode register or
//                   forward combine logic exists.
//
// Stage split
//   PIPE=1 : one register after the full combine
//   PIPE=2 : stage 1 holds {a, 2a, 4a, 8a} per byte (+ mode), stage 2 the result
//   PIPE=3 : as PIPE=2 plus an output register
// ---------------------------------------------------------------------------
module mix_columns_pipe
    import aes_pkg::*;
#(
    parameter int NCOL = 4,
    parameter int PIPE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_inv,
    input  logic [COL_W*NCOL-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [COL_W*NCOL-1:0] out_data
);

    localparam int NB = ROWS * NCOL;     // bytes per beat
    localparam int W  = COL_W * NCOL;    // beat width

    // ------------------------------------------------------------------
    // Combine functions: operate on flat byte vectors holding a, 2a, 4a, 8a
    // ------------------------------------------------------------------
    function automatic gf_byte_t byte_at(input logic [NB*BYTE_W-1:0] v, input int idx);
        return v[idx*BYTE_W +: BYTE_W];
    endfunction

    // r_i = 14*a_i ^ 11*a_(i+1) ^ 13*a_(i+2) ^ 9*a_(i+3)
    function automatic logic [W-1:0] inv_mix(
        input logic [NB*BYTE_W-1:0] a,
        input logic [NB*BYTE_W-1:0] x2,
        input logic [NB*BYTE_W-1:0] x4,
        input logic [NB*BYTE_W-1:0] x8
    );
        logic [W-1:0] r;
        int p0, p1, p2, p3;
        r = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int i = 0; i < ROWS; i++) begin
                p0 = byte_idx(c, i);
                p1 = byte_idx(c, (i + 1) % ROWS);
                p2 = byte_idx(c, (i + 2) % ROWS);
                p3 = byte_idx(c, (i + 3) % ROWS);
                r[p0*BYTE_W +: BYTE_W] =
                      (byte_at(x8, p0) ^ byte_at(x4, p0) ^ byte_at(x2, p0))
                    ^ (byte_at(x8, p1) ^ byte_at(x2, p1) ^ byte_at(a, p1))
                    ^ (byte_at(x8, p2) ^ byte_at(x4, p2) ^ byte_at(a, p2))
                    ^ (byte_at(x8, p3) ^ byte_at(a, p3));
            end
        end
        return r;
    endfunction

`ifdef MIXCOL_FWD_EN
    // r_i = 2*a_i ^ 3*a_(i+1) ^ a_(i+2) ^ a_(i+3)
    function automatic logic [W-1:0] fwd_mix(
        input logic [NB*BYTE_W-1:0] a,
        input logic [NB*BYTE_W-1:0] x2
    );
        logic [W-1:0] r;
        int p0, p1, p2, p3;
        r = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int i = 0; i < ROWS; i++) begin
                p0 = byte_idx(c, i);
                p1 = byte_idx(c, (i + 1) % ROWS);
                p2 = byte_idx(c, (i + 2) % ROWS);
                p3 = byte_idx(c, (i + 3) % ROWS);
                r[p0*BYTE_W +: BYTE_W] =
                      byte_at(x2, p0)
                    ^ (byte_at(x2, p1) ^ byte_at(a, p1))
                    ^ byte_at(a, p2)
                    ^ byte_at(a, p3);
            end
        end
        return r;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Handshake chain
    //   go[k] : stage k hands its beat on this cycle
    //   ld[k] : stage k captures a new beat this cycle
    // in_ready is combinational from out_ready through the chain so a full
    // pipeline still accepts while it drains.
    // ------------------------------------------------------------------
    logic [PIPE-1:0] vld;
    logic [PIPE-1:0] go;
    logic [PIPE-1:0] ld;

    always_comb begin
        logic nxt;
        go  = '0;
        nxt = vld[PIPE-1] & out_ready;
        go[PIPE-1] = nxt;
        for (int k = PIPE - 2; k >= 0; k--) begin
            nxt   = vld[k] & (~vld[k+1] | nxt);
            go[k] = nxt;
        end
    end

    assign in_ready = ~vld[0] | go[0];

    always_comb begin
        ld    = '0;
        ld[0] = in_valid & in_ready;
        for (int k = 1; k < PIPE; k++) begin
            ld[k] = go[k-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld <= ld | (vld & ~go);
        end
    end

    // ------------------------------------------------------------------
    // xtime chains on the incoming beat
    // ------------------------------------------------------------------
    logic [NB*BYTE_W-1:0] x2_c;
    logic [NB*BYTE_W-1:0] x4_c;
    logic [NB*BYTE_W-1:0] x8_c;

    for (genvar gi = 0; gi < NB; gi++) begin : g_xt
        gf_xtime_chain u_xt (
            .a  (in_data[gi*BYTE_W +: BYTE_W]),
            .x2 (x2_c[gi*BYTE_W +: BYTE_W]),
            .x4 (x4_c[gi*BYTE_W +: BYTE_W]),
            .x8 (x8_c[gi*BYTE_W +: BYTE_W])
        );
    end

    // Operands feeding the combine: live inputs for PIPE=1, stage-1
    // registers otherwise.
    logic [NB*BYTE_W-1:0] s_a;
    logic [NB*BYTE_W-1:0] s_x2;
    logic [NB*BYTE_W-1:0] s_x4;
    logic [NB*BYTE_W-1:0] s_x8;
    logic [W-1:0]         res_c;
    logic [W-1:0]         data_q;

`ifdef MIXCOL_FWD_EN
    logic s_inv;
    assign res_c = s_inv ? inv_mix(s_a, s_x2, s_x4, s_x8) : fwd_mix(s_a, s_x2);
`else
    // Inverse-only: the mode pin has no effect.
    logic unused_inv;
    assign unused_inv = in_inv;
    assign res_c      = inv_mix(s_a, s_x2, s_x4, s_x8);
`endif

    if (PIPE == 1) begin : g_pipe1
        assign s_a  = in_data;
        assign s_x2 = x2_c;
        assign s_x4 = x4_c;
        assign s_x8 = x8_c;
`ifdef MIXCOL_FWD_EN
        assign s_inv = in_inv;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (ld[0]) begin
                data_q <= res_c;
            end
        end
    end else begin : g_pipe_n
        logic [W-1:0] mid_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_a  <= '0;
                s_x2 <= '0;
                s_x4 <= '0;
                s_x8 <= '0;
            end else if (ld[0]) begin
                s_a  <= in_data;
                s_x2 <= x2_c;
                s_x4 <= x4_c;
                s_x8 <= x8_c;
            end
        end

`ifdef MIXCOL_FWD_EN
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_inv <= 1'b0;
            end else if (ld[0]) begin
                s_inv <= in_inv;
            end
        end
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mid_q <= '0;
            end else if (ld[1]) begin
                mid_q <= res_c;
            end
        end

        if (PIPE == 3) begin : g_out_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q <= '0;
                end else if (ld[2]) begin
                    data_q <= mid_q;
                end
            end
        end else begin : g_no_out_reg
            assign data_q = mid_q;
        end
    end

    assign out_valid = vld[PIPE-1];
    assign out_data  = data_q;

endmodule
